// File: rtl/ram_master.sv
// Initiator for a single-port synchronous RAM: accepts burst read/write requests,
// issues one RAM access per cycle and returns read data one cycle after each address.
module ram_master #(
  parameter int BUS_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [BUS_WIDTH-1:0]  reqAddr,
  input  logic [LEN_WIDTH-1:0]  reqLen,
  input  logic                  wrValid,
  output logic                  wrReady,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  rspValid,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic                  rspLast,
  output logic                  done,
  output logic [BUS_WIDTH-1:0]  ramAddr,
  output logic [DATA_WIDTH-1:0] ramDataIn,
  output logic                  ramWrEnable,
  input  logic [DATA_WIDTH-1:0] ramDataOut
);

  typedef enum logic [1:0] {IDLE, READ, READ_LAST, WRITE} state_t;

  state_t               state, state_nxt;
  logic [BUS_WIDTH-1:0] curAddr, curAddr_nxt;
  logic [LEN_WIDTH-1:0] remaining, remaining_nxt;
  logic                 vld_p1, last_p1, done_p1;
  logic                 vld_nxt, last_nxt, done_nxt;

  // Stage p0 -> p1: address issue registers alongside the RAM's own output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      curAddr   <= '0;
      remaining <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      done_p1   <= 1'b0;
    end else begin
      state     <= state_nxt;
      curAddr   <= curAddr_nxt;
      remaining <= remaining_nxt;
      vld_p1    <= vld_nxt;
      last_p1   <= last_nxt;
      done_p1   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    curAddr_nxt   = curAddr;
    remaining_nxt = remaining;
    vld_nxt       = 1'b0;
    last_nxt      = 1'b0;
    done_nxt      = 1'b0;
    reqReady      = 1'b0;
    wrReady       = 1'b0;
    ramWrEnable   = 1'b0;
    case (state)
      IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          curAddr_nxt   = reqAddr;
          remaining_nxt = reqLen;
          state_nxt     = reqWrite ? WRITE : READ;
        end
      end
      READ: begin
        vld_nxt     = 1'b1;
        curAddr_nxt = curAddr + 1'b1;
        if (remaining == '0) begin
          last_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = READ_LAST;
        end else begin
          remaining_nxt = remaining - 1'b1;
        end
      end
      READ_LAST: state_nxt = IDLE;
      WRITE: begin
        wrReady     = 1'b1;
        ramWrEnable = wrValid;
        if (wrValid) begin
          curAddr_nxt = curAddr + 1'b1;
          if (remaining == '0) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            remaining_nxt = remaining - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ramAddr   = curAddr;
  assign ramDataIn = wrData;
  assign rspValid  = vld_p1;
  assign rspLast   = last_p1;
  assign done      = done_p1;
  assign rspData   = ramDataOut;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural single-port synchronous RAM.
module tb_ram_master;
  localparam int BW = 8;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reqValid = 1'b0, reqReady, reqWrite = 1'b0;
  logic [BW-1:0] reqAddr = '0;
  logic [LW-1:0] reqLen = '0;
  logic          wrValid = 1'b0, wrReady;
  logic [DW-1:0] wrData = '0;
  logic          rspValid, rspLast, done;
  logic [DW-1:0] rspData;
  logic [BW-1:0] ramAddr;
  logic [DW-1:0] ramDataIn, ramDataOut;
  logic          ramWrEnable;

  ram_master #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqLen(reqLen),
    .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
    .rspValid(rspValid), .rspData(rspData), .rspLast(rspLast), .done(done),
    .ramAddr(ramAddr), .ramDataIn(ramDataIn), .ramWrEnable(ramWrEnable),
    .ramDataOut(ramDataOut)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registered read, write counter for burst accounting
  logic [DW-1:0] mem [256];
  int            wr_count = 0;
  always @(posedge clk) begin
    if (ramWrEnable) begin
      mem[ramAddr] <= ramDataIn;
      wr_count     <= wr_count + 1;
    end
    ramDataOut <= mem[ramAddr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [7:0] a, input logic [3:0] l);
    int k;
    k = 0;
    reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqLen = l;
    @(negedge clk);
    while (!reqReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_accept", {31'd0, reqReady}, 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0; reqWrite = ~wr; reqAddr = ~a; reqLen = ~l;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] l, input logic [31:0] d0, input int gap);
    int w0;
    request(1'b1, a, l);
    w0 = wr_count;
    for (int i = 0; i <= int'(l); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          wrValid = 1'b0;
          @(negedge clk);
          chk("stall_we", {31'd0, ramWrEnable}, 32'd0);
          chk("stall_addr", {24'd0, ramAddr}, {24'd0, 8'(int'(a) + i)});
          chk("stall_done", {31'd0, done}, 32'd0);
          tick();
        end
      end
      wrValid = 1'b1; wrData = d0 + i;
      @(negedge clk);
      chk("wr_ready", {31'd0, wrReady}, 32'd1);
      chk("wr_we", {31'd0, ramWrEnable}, 32'd1);
      chk("wr_addr", {24'd0, ramAddr}, {24'd0, 8'(int'(a) + i)});
      chk("wr_done_early", {31'd0, done}, 32'd0);
      tick();
    end
    wrValid = 1'b0;
    @(negedge clk);
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_idle", {31'd0, reqReady}, 32'd1);
    chk("wr_count", wr_count - w0, int'(l) + 1);
    tick();
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] l, input logic [3:0][31:0] exp);
    request(1'b0, a, l);
    for (int c = 0; c <= int'(l) + 1; c++) begin
      @(negedge clk);
      chk("rd_busy", {31'd0, reqReady}, 32'd0);
      chk("rd_we", {31'd0, ramWrEnable}, 32'd0);
      if (c == 0) begin
        chk("rd_latency", {31'd0, rspValid}, 32'd0);
      end else begin
        chk("rd_vld", {31'd0, rspValid}, 32'd1);
        chk("rd_data", rspData, exp[c-1]);
        chk("rd_last", {31'd0, rspLast}, {31'd0, (c - 1 == int'(l))});
        chk("rd_done", {31'd0, done}, {31'd0, (c - 1 == int'(l))});
      end
      tick();
    end
    @(negedge clk);
    chk("rd_idle", {31'd0, reqReady}, 32'd1);
    chk("rd_vld_end", {31'd0, rspValid}, 32'd0);
    tick();
  endtask

  typedef struct packed {
    logic             wr;
    logic [7:0]       addr;
    logic [3:0]       len;
    logic [31:0]      d0;
    logic [3:0][31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [3:0] l,
                              input logic [31:0] d0, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.d0 = d0;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  vec_t tbl [8];

  initial begin
    int w0;
    tbl[0] = mk(1'b1, 8'h10, 4'd3, 32'hA000_0000, 0, 0, 0, 0);
    tbl[1] = mk(1'b0, 8'h10, 4'd3, 0, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);
    tbl[2] = mk(1'b1, 8'hFF, 4'd2, 32'hB000_0000, 0, 0, 0, 0);
    tbl[3] = mk(1'b0, 8'hFF, 4'd2, 0, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 0);
    tbl[4] = mk(1'b0, 8'h12, 4'd0, 0, 32'hA000_0002, 0, 0, 0);
    tbl[5] = mk(1'b1, 8'h11, 4'd1, 32'hC000_0000, 0, 0, 0, 0);
    tbl[6] = mk(1'b0, 8'h10, 4'd3, 0, 32'hA000_0000, 32'hC000_0000, 32'hC000_0001, 32'hA000_0003);
    tbl[7] = mk(1'b1, 8'h80, 4'd3, 32'hE000_0000, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
    chk("rst_wrReady", {31'd0, wrReady}, 32'd0);
    chk("rst_we", {31'd0, ramWrEnable}, 32'd0);
    chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
    chk("rst_rspLast", {31'd0, rspLast}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {24'd0, ramAddr}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 8; t++) begin
      if (tbl[t].wr) do_write(tbl[t].addr, tbl[t].len, tbl[t].d0, 0);
      else           do_read(tbl[t].addr, tbl[t].len, tbl[t].exp);
    end

    // Write stall: wrValid 1,0,0,1 for a two-beat burst
    do_write(8'h40, 4'd1, 32'hF000_0000, 2);
    do_read(8'h40, 4'd1, {32'd0, 32'd0, 32'hF000_0001, 32'hF000_0000});

    // Reset in the middle of an 8-beat write burst
    request(1'b1, 8'h80, 4'd7);
    w0 = wr_count;
    wrValid = 1'b1; wrData = 32'hD000_0000; tick();
    wrData = 32'hD000_0001; tick();
    wrData = 32'hD000_0002;
    #1;
    chk("mid_we_before", {31'd0, ramWrEnable}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_drop", {31'd0, ramWrEnable}, 32'd0);
    chk("mid_wrReady_drop", {31'd0, wrReady}, 32'd0);
    chk("mid_idle", {31'd0, reqReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    wrValid = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_no_done2", {31'd0, done}, 32'd0);
    chk("mid_wr_count", wr_count - w0, 32'd2);
    tick();
    do_read(8'h80, 4'd3, {32'hE000_0003, 32'hE000_0002, 32'hD000_0001, 32'hD000_0000});

    // Request held during a busy read burst, then a single-beat read
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 8'h10; reqLen = 4'd3;
    @(negedge clk);
    chk("busy_first_rdy", {31'd0, reqReady}, 32'd1);
    @(posedge clk);
    #1;
    reqAddr = 8'h13; reqLen = 4'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("busy_hold", {31'd0, reqReady}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("busy_accept", {31'd0, reqReady}, 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(negedge clk);
    chk("single_lat", {31'd0, rspValid}, 32'd0);
    tick();
    @(negedge clk);
    chk("single_vld", {31'd0, rspValid}, 32'd1);
    chk("single_data", rspData, 32'hA000_0003);
    chk("single_last", {31'd0, rspLast}, 32'd1);
    chk("single_done", {31'd0, done}, 32'd1);
    tick();
    @(negedge clk);
    chk("single_idle", {31'd0, reqReady}, 32'd1);
    chk("single_vld_end", {31'd0, rspValid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
